// File: rtl/fmiller_encoder_if.sv
// Byte stream into the modified-Miller encoder: valid/ready handshake with a
// frame-terminating last flag.
interface fmiller_encoder_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] s_data;
  logic              s_valid;
  logic              s_last;
  logic              s_ready;

  modport master (output s_data, output s_valid, output s_last, input s_ready);
  modport slave  (input s_data, input s_valid, input s_last, output s_ready);
endinterface

// File: rtl/fmiller_encoder.sv
// Modified-Miller (pause) transmit encoder: buffers stream words, frames them
// with SOF/EOF and emits the pause waveform one half-bit slot at a time.
module fmiller_encoder #(
  parameter int DATA_W   = 8,
  parameter int HALF_CYC = 1
) (
  input  logic             clk2x,
  input  logic             rst_n,
  input  logic             enable,
  fmiller_encoder_if.slave s,
  output wire              dout,
  output logic             busy,
  output logic             err_underrun
);
  localparam int SLOT_W = (HALF_CYC > 1) ? $clog2(HALF_CYC) : 1;
  localparam int CNT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [SLOT_W-1:0] SLOT_MAX = SLOT_W'(HALF_CYC - 1);
  localparam logic [CNT_W-1:0]  BIT_MAX  = CNT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SOF  = 3'd1,
    ST_DATA = 3'd2,
    ST_EOF0 = 3'd3,
    ST_EOFY = 3'd4
  } state_t;

  state_t              state_r, state_n;
  logic                half_r, half_n;
  logic [SLOT_W-1:0]   slot_r, slot_n;
  logic [CNT_W-1:0]    bitcnt_r, bitcnt_n;
  logic [DATA_W-1:0]   shift_r, shift_n;
  logic                prev_r, prev_n;
  logic                last_r, last_n;
  logic [DATA_W-1:0]   buf_r;
  logic                buf_last_r;
  logic                buf_full_r, buf_full_n;
  logic                ready_r, ready_n;
  logic                dout_r, dout_n;
  logic                busy_r, busy_n;
  logic                err_r;
  logic                slot_end_s, bit_end_s, accept_s, drain_s, underrun_s;

  // Slot value for a given position; prev is the previous bit (SOF counts as 0).
  function automatic logic sym_f(input state_t st, input logic h, input logic b, input logic p);
    logic v;
    case (st)
      ST_SOF:  v = ~h;
      ST_DATA: v = b ? h : (~h & ~p);
      ST_EOF0: v = ~h & ~p;
      default: v = 1'b0;
    endcase
    return v;
  endfunction

  assign slot_end_s = (slot_r == SLOT_MAX);
  assign bit_end_s  = slot_end_s && half_r;
  assign accept_s   = s.s_valid && ready_r;

  // Next-state and datapath sequencing.
  always_comb begin
    state_n    = state_r;
    half_n     = half_r;
    slot_n     = slot_r;
    bitcnt_n   = bitcnt_r;
    shift_n    = shift_r;
    prev_n     = prev_r;
    last_n     = last_r;
    drain_s    = 1'b0;
    underrun_s = 1'b0;
    if (state_r != ST_IDLE) begin
      if (slot_end_s) begin
        slot_n = {SLOT_W{1'b0}};
        half_n = ~half_r;
      end else begin
        slot_n = slot_r + SLOT_W'(1);
      end
    end else begin
      slot_n = {SLOT_W{1'b0}};
      half_n = 1'b0;
    end
    case (state_r)
      ST_IDLE: begin
        if (buf_full_r) begin
          state_n  = ST_SOF;
          shift_n  = buf_r;
          last_n   = buf_last_r;
          prev_n   = 1'b0;
          bitcnt_n = {CNT_W{1'b0}};
          drain_s  = 1'b1;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_SOF: begin
        if (bit_end_s) begin
          state_n  = ST_DATA;
          bitcnt_n = {CNT_W{1'b0}};
        end else begin
          state_n = ST_SOF;
        end
      end
      ST_DATA: begin
        if (bit_end_s) begin
          prev_n = shift_r[0];
          if (bitcnt_r == BIT_MAX) begin
            if (last_r) begin
              state_n = ST_EOF0;
            end else if (buf_full_r) begin
              shift_n  = buf_r;
              last_n   = buf_last_r;
              bitcnt_n = {CNT_W{1'b0}};
              drain_s  = 1'b1;
            end else begin
              underrun_s = 1'b1;
              state_n    = ST_EOF0;
            end
          end else begin
            shift_n  = {1'b0, shift_r[DATA_W-1:1]};
            bitcnt_n = bitcnt_r + CNT_W'(1);
          end
        end else begin
          state_n = ST_DATA;
        end
      end
      ST_EOF0: begin
        if (bit_end_s) begin
          state_n = ST_EOFY;
        end else begin
          state_n = ST_EOF0;
        end
      end
      ST_EOFY: begin
        // A word queued during EOF starts its SOF right after EOFY, no idle gap.
        if (bit_end_s && buf_full_r) begin
          state_n  = ST_SOF;
          shift_n  = buf_r;
          last_n   = buf_last_r;
          prev_n   = 1'b0;
          bitcnt_n = {CNT_W{1'b0}};
          drain_s  = 1'b1;
        end else if (bit_end_s) begin
          state_n = ST_IDLE;
        end else begin
          state_n = ST_EOFY;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Output and buffer next values, all taken from the slot being entered.
  always_comb begin
    if (drain_s) begin
      buf_full_n = 1'b0;
    end else if (accept_s) begin
      buf_full_n = 1'b1;
    end else begin
      buf_full_n = buf_full_r;
    end
    ready_n = ~buf_full_n;
    dout_n  = sym_f(state_n, half_n, shift_n[0], prev_n);
    busy_n  = (state_n != ST_IDLE);
  end

  // State register and registered outputs.
  always_ff @(posedge clk2x or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      half_r     <= 1'b0;
      slot_r     <= {SLOT_W{1'b0}};
      bitcnt_r   <= {CNT_W{1'b0}};
      shift_r    <= {DATA_W{1'b0}};
      prev_r     <= 1'b0;
      last_r     <= 1'b0;
      buf_r      <= {DATA_W{1'b0}};
      buf_last_r <= 1'b0;
      buf_full_r <= 1'b0;
      ready_r    <= 1'b0;
      dout_r     <= 1'b0;
      busy_r     <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      state_r    <= state_n;
      half_r     <= half_n;
      slot_r     <= slot_n;
      bitcnt_r   <= bitcnt_n;
      shift_r    <= shift_n;
      prev_r     <= prev_n;
      last_r     <= last_n;
      buf_r      <= accept_s ? s.s_data : buf_r;
      buf_last_r <= accept_s ? s.s_last : buf_last_r;
      buf_full_r <= buf_full_n;
      ready_r    <= ready_n;
      dout_r     <= dout_n;
      busy_r     <= busy_n;
      err_r      <= underrun_s;
    end
  end

  assign s.s_ready    = ready_r;
  assign dout         = enable ? dout_r : 1'bz;
  assign busy         = busy_r;
  assign err_underrun = err_r;
endmodule

// File: tb/tb_fmiller_encoder.sv
// Scoreboard bench for fmiller_encoder: two instances (HALF_CYC 1 and 4),
// expected slot waveforms queued at stimulus time and popped cycle by cycle.
module tb_fmiller_encoder;
  logic clk2x = 1'b0;
  logic rst_n = 1'b0;
  logic enable1 = 1'b1;
  logic enable4 = 1'b1;
  logic sel = 1'b0;
  wire  dout1, dout4;
  logic busy1, busy4, err1, err4;
  int   checks = 0;
  int   errors = 0;
  int   acc_cnt = 0;
  bit   exp_dout_q[$];
  bit   exp_err_q[$];

  fmiller_encoder_if #(.DATA_W(8)) if1 ();
  fmiller_encoder_if #(.DATA_W(8)) if4 ();

  fmiller_encoder #(.DATA_W(8), .HALF_CYC(1)) u_dut1 (
    .clk2x(clk2x), .rst_n(rst_n), .enable(enable1), .s(if1),
    .dout(dout1), .busy(busy1), .err_underrun(err1)
  );
  fmiller_encoder #(.DATA_W(8), .HALF_CYC(4)) u_dut4 (
    .clk2x(clk2x), .rst_n(rst_n), .enable(enable4), .s(if4),
    .dout(dout4), .busy(busy4), .err_underrun(err4)
  );

  always #5 clk2x = ~clk2x;

  wire obs_dout  = sel ? dout4 : dout1;
  wire obs_busy  = sel ? busy4 : busy1;
  wire obs_err   = sel ? err4 : err1;
  wire obs_ready = sel ? if4.s_ready : if1.s_ready;

  task automatic set_src(input bit v, input logic [7:0] d, input bit l);
    if (sel) begin
      if4.s_valid = v; if4.s_data = d; if4.s_last = l;
    end else begin
      if1.s_valid = v; if1.s_data = d; if1.s_last = l;
    end
  endtask

  task automatic push_sym(input bit h0, input bit h1, input int hc, input bit e);
    for (int j = 0; j < hc; j++) begin
      exp_dout_q.push_back(h0);
      exp_err_q.push_back(e && (j == 0));
    end
    for (int j = 0; j < hc; j++) begin
      exp_dout_q.push_back(h1);
      exp_err_q.push_back(1'b0);
    end
  endtask

  // Expected frame: SOF=Z, X for 1, Z/Y for 0 by previous bit, EOF0 logic 0, EOFY=Y.
  task automatic push_frame(input logic [15:0] data, input int nw, input int hc, input bit urun);
    bit prev;
    prev = 1'b0;
    push_sym(1'b1, 1'b0, hc, 1'b0);
    for (int i = 0; i < 8 * nw; i++) begin
      if (data[i]) push_sym(1'b0, 1'b1, hc, 1'b0);
      else if (!prev) push_sym(1'b1, 1'b0, hc, 1'b0);
      else push_sym(1'b0, 1'b0, hc, 1'b0);
      prev = data[i];
    end
    if (prev) push_sym(1'b0, 1'b0, hc, urun);
    else push_sym(1'b1, 1'b0, hc, urun);
    push_sym(1'b0, 1'b0, hc, 1'b0);
  endtask

  task automatic drive_words(input logic [15:0] data, input int nw, input bit last_final);
    bit ok;
    for (int w = 0; w < nw; w++) begin
      set_src(1'b1, data[8*w +: 8], last_final && (w == nw - 1));
      ok = 1'b0;
      for (int k = 0; k < 100; k++) begin
        @(negedge clk2x);
        if (obs_ready) begin
          @(posedge clk2x); #1;
          ok = 1'b1;
          break;
        end
      end
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL accept word %0d: s_ready never seen in 100 cycles", w);
      end
      acc_cnt++;
    end
    set_src(1'b0, 8'h00, 1'b0);
  endtask

  task automatic check_stream(input bit en, input string tag);
    bit ok, ed, ee;
    int n;
    ok = 1'b0;
    n = 0;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk2x); #2;
      if (acc_cnt > 0) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s start: no word accepted within 200 cycles", tag);
      exp_dout_q.delete();
      exp_err_q.delete();
    end
    while (exp_dout_q.size() > 0) begin
      @(posedge clk2x); #2;
      ed = exp_dout_q.pop_front();
      ee = exp_err_q.pop_front();
      if (n == 0) begin
        checks++;
        if (obs_ready !== 1'b1) begin
          errors++;
          $display("FAIL %s ready_after_drain: got %b want 1", tag, obs_ready);
        end
      end
      checks++;
      if (en) begin
        if (obs_dout !== ed) begin
          errors++;
          $display("FAIL %s dout cycle %0d: got %b want %b", tag, n, obs_dout, ed);
        end
      end else if (obs_dout === 1'b1) begin
        errors++;
        $display("FAIL %s dout_off cycle %0d: got 1 want undriven", tag, n);
      end
      checks++;
      if (obs_busy !== 1'b1) begin
        errors++;
        $display("FAIL %s busy cycle %0d: got %b want 1", tag, n, obs_busy);
      end
      checks++;
      if (obs_err !== ee) begin
        errors++;
        $display("FAIL %s err_underrun cycle %0d: got %b want %b", tag, n, obs_err, ee);
      end
      n++;
    end
    @(posedge clk2x); #2;
    checks++;
    if (obs_busy !== 1'b0) begin
      errors++;
      $display("FAIL %s busy_end after %0d cycles: got %b want 0", tag, n, obs_busy);
    end
    if (en) begin
      checks++;
      if (obs_dout !== 1'b0) begin
        errors++;
        $display("FAIL %s dout_idle: got %b want 0", tag, obs_dout);
      end
    end
  endtask

  task automatic run_frame(input logic [15:0] data, input int nw, input bit last,
                           input bit s4, input bit en, input string tag);
    sel = s4;
    enable4 = s4 ? en : 1'b1;
    acc_cnt = 0;
    push_frame(data, nw, s4 ? 4 : 1, !last);
    fork
      drive_words(data, nw, last);
      check_stream(en, tag);
    join
    repeat (2) @(posedge clk2x);
    #2;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({dout1, busy1, if1.s_ready, err1} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_values: got %b want 0000", {dout1, busy1, if1.s_ready, err1});
    end
    @(negedge clk2x);
    rst_n = 1'b1;
    #1;
    checks++;
    if (if1.s_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready_before_edge: got %b want 0", if1.s_ready);
    end
    @(posedge clk2x); #2;
    checks++;
    if (if1.s_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready_after_edge: got %b want 1", if1.s_ready);
    end
  endtask

  task automatic test_a5();
    run_frame(16'h00A5, 1, 1'b1, 1'b0, 1'b1, "a5");
  endtask

  task automatic test_zero();
    run_frame(16'h0000, 1, 1'b1, 1'b0, 1'b1, "zero");
  endtask

  task automatic test_back_to_back();
    run_frame(16'h01FF, 2, 1'b1, 1'b0, 1'b1, "b2b");
    run_frame(16'h5AC3, 2, 1'b1, 1'b0, 1'b1, "b2b_mix");
  endtask

  task automatic test_underrun();
    run_frame(16'h003C, 1, 1'b0, 1'b0, 1'b1, "underrun");
  endtask

  task automatic test_reset_mid();
    sel = 1'b0;
    acc_cnt = 0;
    drive_words(16'h0055, 1, 1'b1);
    repeat (7) @(posedge clk2x);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({dout1, busy1} !== 2'b00) begin
      errors++;
      $display("FAIL abort_async: got dout/busy %b want 00", {dout1, busy1});
    end
    @(posedge clk2x); #2;
    rst_n = 1'b1;
    checks++;
    if ({dout1, busy1, err1} !== 3'b000) begin
      errors++;
      $display("FAIL abort_held: got dout/busy/err %b want 000", {dout1, busy1, err1});
    end
    run_frame(16'h00A5, 1, 1'b1, 1'b0, 1'b1, "a5_after_abort");
  endtask

  task automatic test_stretch();
    run_frame(16'h00A5, 1, 1'b1, 1'b1, 1'b0, "hc4_disabled");
    run_frame(16'h00A5, 1, 1'b1, 1'b1, 1'b1, "hc4_enabled");
  endtask

  initial begin
    if1.s_valid = 1'b0; if1.s_data = 8'h00; if1.s_last = 1'b0;
    if4.s_valid = 1'b0; if4.s_data = 8'h00; if4.s_last = 1'b0;
    test_reset();
    test_a5();
    test_zero();
    test_back_to_back();
    test_underrun();
    test_reset_mid();
    test_stretch();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
